// File: rtl/test_pattern_gen.sv
// Test pattern source: ZERO/ONES/TOGGLE/COUNT/PRBS words over a valid/ready stream.
// Optional error injection on data bit 0 is enabled by defining TPG_ERR_INJECT_EN.
module test_pattern_gen #(
  parameter int          DATA_W   = 8,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] SEED_DEF = 32'h0000_0001
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [2:0]        mode_i,
  input  logic [31:0]       seed_i,
  input  logic [LEN_W-1:0]  burst_len_i,
`ifdef TPG_ERR_INJECT_EN
  input  logic              err_inj_i,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] M_ONES   = 3'd1;
  localparam logic [2:0] M_TOGGLE = 3'd2;
  localparam logic [2:0] M_COUNT  = 3'd3;
  localparam logic [2:0] M_PRBS   = 3'd4;

  state_t             state_q;
  logic [2:0]         mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [31:0]        pat_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               done_q;

  logic               xfer;
  logic [LEN_W-1:0]   cnt_d;
  logic               last_xfer;
  logic               leave_run;
  logic [31:0]        seed_eff;
  logic [31:0]        start_pat;
  logic [31:0]        pat_d;

  // Galois right-shift LFSR, x^32+x^22+x^2+x+1 (tap k maps to bit k-1)
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  function automatic logic [DATA_W-1:0] pat_word(input logic [2:0] m, input logic [31:0] p);
    logic [31:0] w;
    case (m)
      M_ONES:          w = '1;
      M_TOGGLE:        w = p[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      M_COUNT, M_PRBS: w = p;
      default:         w = '0;
    endcase
    return w[DATA_W-1:0];
  endfunction

  assign xfer      = (state_q == RUN) && valid_q && ready_i;
  assign cnt_d     = cnt_q + LEN_W'(1);
  assign last_xfer = xfer && (len_q != '0) && (cnt_d == len_q);
  assign leave_run = (state_q == RUN) && (stop_i || last_xfer);
  assign seed_eff  = (seed_i == 32'h0) ? SEED_DEF : seed_i;
  // TOGGLE uses pat bit 0 as its phase, so it always starts from 0x55..
  assign start_pat = (mode_i == M_TOGGLE) ? 32'h0 : seed_eff;

  always_comb begin
    pat_d = pat_q;
    case (mode_q)
      M_TOGGLE: pat_d = pat_q ^ 32'h1;
      M_COUNT:  pat_d = pat_q + 32'h1;
      M_PRBS:   pat_d = lfsr_next(pat_q);
      default:  pat_d = pat_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= SEED_DEF;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            mode_q  <= mode_i;
            len_q   <= burst_len_i;
            cnt_q   <= '0;
            pat_q   <= start_pat;
            data_q  <= pat_word(mode_i, start_pat);
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) cnt_q <= cnt_d;
          if (stop_i || last_xfer) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (xfer) begin
            pat_q  <= pat_d;
            data_q <= pat_word(mode_q, pat_d);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;

`ifdef TPG_ERR_INJECT_EN
  logic        armed_q;
  logic [15:0] err_cnt_q;

  // A pulse coincident with a transfer arms the following beat, not the current one
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      armed_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (xfer && armed_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (state_q != RUN || leave_run) armed_q <= 1'b0;
      else if (err_inj_i)              armed_q <= 1'b1;
      else if (xfer)                   armed_q <= 1'b0;
    end
  end

  assign data_o    = data_q ^ {{(DATA_W-1){1'b0}}, armed_q};
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_leave;
  assign unused_leave = leave_run;
  assign data_o       = data_q;
  assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen (DATA_W=8); injection test only when TPG_ERR_INJECT_EN is defined.
module tb_test_pattern_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start_i, stop_i, ready_i;
  logic [2:0]  mode_i;
  logic [31:0] seed_i;
  logic [15:0] burst_len_i;
  logic [7:0]  data_o;
  logic        valid_o, busy_o, done_o;
  logic [15:0] err_cnt_o;
`ifdef TPG_ERR_INJECT_EN
  logic        err_inj_i;
`endif

  int tests = 0;
  int fails = 0;

  test_pattern_gen #(.DATA_W(8), .LEN_W(16), .SEED_DEF(32'h0000_0001)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mode_i      (mode_i),
    .seed_i      (seed_i),
    .burst_len_i (burst_len_i),
`ifdef TPG_ERR_INJECT_EN
    .err_inj_i   (err_inj_i),
`endif
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_burst(input logic [2:0] m, input logic [31:0] s, input logic [15:0] l);
    mode_i = m; seed_i = s; burst_len_i = l; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b0; start_i = 0; stop_i = 0; ready_i = 0;
    mode_i = 0; seed_i = 0; burst_len_i = 0;
`ifdef TPG_ERR_INJECT_EN
    err_inj_i = 0;
`endif
    #3;
    tests++;
    if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b done=%b, expected 00/0/0/0", data_o, valid_o, busy_o, done_o);
    end
    tests++;
    if (err_cnt_o !== 16'h0) begin
      fails++; $display("FAIL reset_err_cnt: got %h expected 0000", err_cnt_o);
    end
    tick(); tick();
    sys_rst = 1'b1;
    tick();
  endtask

  task automatic test_count;
    logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    ready_i = 1'b1;
    start_burst(3'd3, 32'h0000_00FE, 16'd4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (valid_o !== 1'b1 || data_o !== exp[i] || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL count_beat%0d: valid=%b data=%h busy=%b, expected 1/%h/1", i, valid_o, data_o, busy_o, exp[i]);
      end
      tick();
    end
    tests++;
    if (done_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL count_done: done=%b valid=%b busy=%b, expected 1/0/0", done_o, valid_o, busy_o);
    end
    tick();
    tests++;
    if (done_o !== 1'b0) begin
      fails++; $display("FAIL count_done_width: done=%b expected 0", done_o);
    end
  endtask

  task automatic test_toggle_stall;
    logic [7:0] exp [3] = '{8'h55, 8'hAA, 8'h55};
    logic [7:0] prev;
    logic       pv, pr;
    int nb = 0, dn = 0, c = 0;
    ready_i = 1'b1;
    start_burst(3'd2, 32'h1234_5678, 16'd3);
    while (dn == 0 && c < 20) begin
      ready_i = (c % 2 == 0);
      prev = data_o; pv = valid_o; pr = ready_i;
      if (valid_o && ready_i && nb < 3) begin
        tests++;
        if (data_o !== exp[nb]) begin
          fails++; $display("FAIL toggle_beat%0d: data=%h expected %h", nb, data_o, exp[nb]);
        end
        nb++;
      end
      tick();
      if (done_o) dn++;
      if (!pr && pv && valid_o) begin
        tests++;
        if (data_o !== prev) begin
          fails++; $display("FAIL toggle_stall_hold: data=%h expected %h", data_o, prev);
        end
      end
      c++;
    end
    tests++;
    if (nb != 3 || dn != 1) begin
      fails++; $display("FAIL toggle_count: beats=%0d dones=%0d expected 3/1", nb, dn);
    end
    ready_i = 1'b1;
    tick();
  endtask

  task automatic test_prbs;
    // Hand-derived: seed 1 -> 0x80200003 -> 0xC0300002
    logic [7:0] exp [3] = '{8'h01, 8'h03, 8'h02};
    ready_i = 1'b1;
    start_burst(3'd4, 32'h0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (valid_o !== 1'b1 || data_o !== exp[i]) begin
        fails++; $display("FAIL prbs_beat%0d: valid=%b data=%h expected 1/%h", i, valid_o, data_o, exp[i]);
      end
      tick();
    end
    tests++;
    if (done_o !== 1'b1) begin
      fails++; $display("FAIL prbs_done: done=%b expected 1", done_o);
    end
    tick();
  endtask

  task automatic test_continuous_stop;
    int bad = 0;
    ready_i = 1'b1;
    start_burst(3'd1, 32'h0, 16'd0);
    for (int i = 0; i < 100; i++) begin
      if (valid_o !== 1'b1 || data_o !== 8'hFF) bad++;
      if (i == 50) begin start_i = 1'b1; mode_i = 3'd0; end
      tick();
      start_i = 1'b0;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL cont_beats: %0d bad beats of 100, expected 0", bad);
    end
    tests++;
    if (valid_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++; $display("FAIL cont_still_running: valid=%b busy=%b expected 1/1", valid_o, busy_o);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tests++;
    if (valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL cont_stop: valid=%b done=%b busy=%b expected 0/1/0", valid_o, done_o, busy_o);
    end
    tick();
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL cont_single_done: done=%b busy=%b expected 0/0", done_o, busy_o);
    end
`ifndef TPG_ERR_INJECT_EN
    tests++;
    if (err_cnt_o !== 16'h0) begin
      fails++; $display("FAIL err_cnt_tied: got %h expected 0000", err_cnt_o);
    end
`endif
  endtask

  task automatic test_reset_mid;
    ready_i = 1'b1;
    start_burst(3'd3, 32'h10, 16'd0);
    tick(); tick(); tick();
    tests++;
    if (data_o !== 8'h13) begin
      fails++; $display("FAIL rstmid_pre: data=%h expected 13", data_o);
    end
    #2 sys_rst = 1'b0;
    #1;
    tests++;
    if (data_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: data=%h valid=%b busy=%b done=%b expected 00/0/0/0", data_o, valid_o, busy_o, done_o);
    end
    tick();
    sys_rst = 1'b1;
    tick();
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL rstmid_no_done: done=%b busy=%b expected 0/0", done_o, busy_o);
    end
    start_burst(3'd3, 32'h20, 16'd2);
    tests++;
    if (data_o !== 8'h20 || valid_o !== 1'b1) begin
      fails++; $display("FAIL rstmid_restart0: data=%h valid=%b expected 20/1", data_o, valid_o);
    end
    tick();
    tests++;
    if (data_o !== 8'h21 || valid_o !== 1'b1) begin
      fails++; $display("FAIL rstmid_restart1: data=%h valid=%b expected 21/1", data_o, valid_o);
    end
    tick();
    tests++;
    if (done_o !== 1'b1) begin
      fails++; $display("FAIL rstmid_restart_done: done=%b expected 1", done_o);
    end
    tick();
  endtask

  task automatic test_boundary;
    ready_i = 1'b1;
    start_burst(3'd5, 32'hFFFF_FFFF, 16'd1);
    tests++;
    if (data_o !== 8'h00 || valid_o !== 1'b1) begin
      fails++; $display("FAIL reserved_zero: data=%h valid=%b expected 00/1", data_o, valid_o);
    end
    tick();
    tests++;
    if (done_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++; $display("FAIL len1_done: done=%b valid=%b expected 1/0", done_o, valid_o);
    end
    tick();
    ready_i = 1'b0;
    start_burst(3'd3, 32'h07, 16'd5);
    tick(); tick();
    tests++;
    if (data_o !== 8'h07 || valid_o !== 1'b1) begin
      fails++; $display("FAIL stall_hold: data=%h valid=%b expected 07/1", data_o, valid_o);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tests++;
    if (valid_o !== 1'b0 || done_o !== 1'b1) begin
      fails++; $display("FAIL stop_drop: valid=%b done=%b expected 0/1", valid_o, done_o);
    end
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL stop_idle_ignored: done=%b busy=%b expected 0/0", done_o, busy_o);
    end
    ready_i = 1'b1;
  endtask

`ifdef TPG_ERR_INJECT_EN
  task automatic test_err_inject;
    logic [7:0] exp [4] = '{8'h00, 8'h00, 8'h01, 8'h00};
    ready_i = 1'b1;
    start_burst(3'd0, 32'h0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (data_o !== exp[i]) begin
        fails++; $display("FAIL inj_beat%0d: data=%h expected %h", i, data_o, exp[i]);
      end
      err_inj_i = (i == 1);
      tick();
      err_inj_i = 1'b0;
    end
    tests++;
    if (err_cnt_o !== 16'd1) begin
      fails++; $display("FAIL inj_err_cnt: got %0d expected 1", err_cnt_o);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_toggle_stall();
    test_prbs();
    test_continuous_stop();
    test_reset_mid();
    test_boundary();
`ifdef TPG_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
- Parametrised successor to the single-bit constant-output test top.
- Generates a DATA_W-bit test data stream in one of five selectable patterns, for a bounded or continuous burst.
- Output uses a valid/ready handshake.
- Used as the stimulus source on board bring-up tops, ahead of any sink (UART, FIFO, DDR write path).

Parameters:
DATA_W, 8, output data width; legal range 1..32
LEN_W, 16, width of burst length input and internal beat counter
SEED_DEF, 32'h0000_0001, LFSR/counter seed used when seed_i is zero

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  asynchronous, active-low reset
start_i  input  1  one-cycle pulse; starts a burst when idle
stop_i  input  1  one-cycle pulse; aborts a running burst
mode_i  input  3  pattern select, sampled on accepted start
seed_i  input  32  seed, sampled on accepted start
burst_len_i  input  LEN_W  beats per burst, sampled on accepted start; 0 = continuous
data_o  output  DATA_W  pattern data
valid_o  output  1  data_o is valid
ready_i  input  1  sink accepts the beat when valid_o && ready_i
busy_o  output  1  high while in RUN
done_o  output  1  one-cycle pulse at burst end or abort
err_cnt_o  output  16  number of injected errors (see Optional Feature)

Behaviour:
- Reset (sys_rst=0, asynchronous): state=IDLE, data_o=0, valid_o=0, busy_o=0, done_o=0, beat counter=0, err_cnt_o=0, LFSR=SEED_DEF.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start_i=1.
  - Latches mode_i, burst_len_i and the seed; a zero seed_i is replaced by SEED_DEF.
  - Loads the first pattern word into data_o and asserts valid_o on the next cycle (latency 1 from start_i).
- RUN:
  - A beat is transferred when valid_o && ready_i.
  - On each transfer the next word is presented in the following cycle, so valid_o stays high back-to-back: one beat per cycle with ready_i held high.
  - While ready_i=0, data_o and valid_o are held stable.
  - Beat counter increments per transfer. When a nonzero burst_len is reached on the final transfer: RUN -> DONE, valid_o deasserts the next cycle.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then -> IDLE.
- stop_i in RUN: -> DONE next cycle regardless of handshake.
  - A pending un-accepted beat is dropped (valid_o falls).
  - If stop_i and a final transfer coincide, a single done_o pulse is issued.
- start_i is ignored in RUN and DONE. stop_i is ignored in IDLE.
- busy_o = (state==RUN). valid_o is low outside RUN.
- Patterns (mode latched at start):
  - 0 ZERO: all zeros.
  - 1 ONES: all ones.
  - 2 TOGGLE: 0x55.. first beat, then alternates 0xAA.. / 0x55.., truncated to DATA_W.
  - 3 COUNT: seed[DATA_W-1:0] first, +1 per transfer, wraps modulo 2^DATA_W.
  - 4 PRBS: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, shifted once per transfer; data_o = lfsr[DATA_W-1:0].
  - 5..7: reserved, treated as ZERO.
- Beat counter is LEN_W bits.
  - Continuous mode (len=0): the counter wraps silently and never terminates.
  - Bounded mode: the maximum burst is 2^LEN_W-1 beats.
- Reset mid-burst: immediate return to IDLE. No done_o is generated.

Optional Feature:
- Macro: TPG_ERR_INJECT_EN.
- When defined, adds input err_inj_i (1 bit).
  - A pulse on err_inj_i in RUN arms a one-shot flag.
  - The next transferred beat has data_o bit 0 inverted; err_cnt_o increments, saturating at 16'hFFFF.
  - The pattern state (counter/LFSR) is unaffected by the injection.
  - The armed flag clears on transfer or on leaving RUN.
- When not defined, err_inj_i is absent and err_cnt_o is tied to 0.

Test Plan:
- DATA_W=8, mode=3, seed=8'hFE, len=4, ready_i=1 -> beats FE, FF, 00, 01 on consecutive cycles; done_o pulse 1 cycle after the last beat.
- mode=2, len=3, ready_i toggling 1/0 -> beats 55, AA, 55; data_o stable during every ready_i=0 cycle.
- mode=4, seed=0, len=3 -> first word = SEED_DEF[7:0] = 01, next words follow the LFSR reference model; no beat is all-zero-locked.
- len=0, mode=1, stop_i after 100 beats -> FF on every beat, valid_o falls, single done_o pulse, busy_o=0.
- sys_rst=0 asserted mid-burst with mode=3 -> all outputs zero asynchronously; no done_o; a new start_i runs normally.
- With TPG_ERR_INJECT_EN defined, mode=0, err_inj_i pulsed at beat 2 -> beat 2 = 01, all other beats 00, err_cnt_o=1.
